// File: rtl/mips_cpu_lsu_if.sv
// Core-side request/response and Avalon-MM data bus signals of the load/store unit.
interface mips_cpu_lsu_if #(
  parameter int unsigned ADDR_W = 24
);
  // Core request / response
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  // Avalon-MM data bus
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic              waitrequest;
  logic [31:0]       readdata;

  // Seen from the load/store unit
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  waitrequest, readdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output address, read, write, byteenable, writedata
  );

  // Seen from the core and memory around the unit
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output waitrequest, readdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  address, read, write, byteenable, writedata
  );
endinterface

// File: rtl/mips_cpu_lsu.sv
// Load/store unit: one core access -> one word-aligned Avalon-MM transaction.
module mips_cpu_lsu #(
  parameter int unsigned ADDR_W = 24
) (
  input logic            clk,
  input logic            reset_n,
  mips_cpu_lsu_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StRlat} state_e;

  state_e            state_q, state_d;
  logic              init_q;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wd_q, wd_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              req_ready;
  logic              misalign;
  logic [3:0]        be_gen;
  logic [31:0]       wd_gen;
  logic [31:0]       shifted;
  logic [31:0]       load_ext;
  logic              unused_addr;

  // Bits above the bus address width are ignored.
  assign unused_addr = ^bus.req_addr[31:ADDR_W];

  // Ready only in IDLE, and only once the first clock after reset has passed.
  assign req_ready = init_q && (state_q == StIdle);

  // Alignment check, lane enables and replicated write data for the incoming request.
  always_comb begin
    misalign = 1'b0;
    be_gen   = 4'b1111;
    wd_gen   = bus.req_wdata;
    unique case (bus.req_size)
      2'd0: begin
        be_gen = 4'b0001 << bus.req_addr[1:0];
        wd_gen = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        misalign = bus.req_addr[0];
        be_gen   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wd_gen   = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        // Size 3 behaves as a word access.
        misalign = |bus.req_addr[1:0];
      end
    endcase
  end

  // Shift the lane-positioned read word down and extend it to 32 bits.
  always_comb begin
    shifted = bus.readdata >> {off_q, 3'b000};
    unique case (size_q)
      2'd0:    load_ext = sgn_q ? {{24{shifted[7]}}, shifted[7:0]}
                                : {24'h0, shifted[7:0]};
      2'd1:    load_ext = sgn_q ? {{16{shifted[15]}}, shifted[15:0]}
                                : {16'h0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    read_d       = read_q;
    write_d      = write_q;
    address_d    = address_q;
    be_d         = be_q;
    wd_d         = wd_q;
    off_d        = off_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid && req_ready) begin
          if (misalign) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            address_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
            be_d      = be_gen;
            wd_d      = wd_gen;
            off_d     = bus.req_addr[1:0];
            size_d    = bus.req_size;
            sgn_d     = bus.req_signed;
            if (bus.req_we) begin
              write_d = 1'b1;
              state_d = StWr;
            end else begin
              read_d  = 1'b1;
              state_d = StRd;
            end
          end
        end
      end
      StRd: begin
        if (!bus.waitrequest) begin
          read_d  = 1'b0;
          state_d = StRlat;
        end
      end
      StWr: begin
        if (!bus.waitrequest) begin
          write_d      = 1'b0;
          state_d      = StIdle;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'h0;
        end
      end
      StRlat: begin
        // readdata is valid this cycle.
        state_d      = StIdle;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = load_ext;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      init_q       <= 1'b0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= '0;
      be_q         <= 4'h0;
      wd_q         <= 32'h0;
      off_q        <= 2'd0;
      size_q       <= 2'd0;
      sgn_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_q       <= 1'b1;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      be_q         <= be_d;
      wd_q         <= wd_d;
      off_q        <= off_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.address    = address_q;
  assign bus.byteenable = be_q;
  assign bus.writedata  = wd_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Directed bench for mips_cpu_lsu with a small Avalon memory model and response scoreboard.
module tb_mips_cpu_lsu;

  logic clk = 1'b0;
  logic reset_n;

  mips_cpu_lsu_if #(.ADDR_W(24)) bus ();

  mips_cpu_lsu #(.ADDR_W(24)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Memory model: stalls each strobe for stall_req cycles, returns readdata a cycle later.
  int          stall_req = 0;
  int          stall_cnt;
  logic [31:0] mem [0:63];

  assign bus.waitrequest = (bus.read || bus.write) && (stall_cnt < stall_req);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt <= 0;
    else if (bus.read || bus.write) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
  end

  always @(posedge clk) begin
    if (bus.read && !bus.waitrequest) bus.readdata <= mem[bus.address[7:2]];
    if (bus.write && !bus.waitrequest) begin
      for (int i = 0; i < 4; i++)
        if (bus.byteenable[i]) mem[bus.address[7:2]][8*i +: 8] <= bus.writedata[8*i +: 8];
    end
  end

  // Bus monitor: strobe history, lane fields, stability and response counts.
  int          strobe_cnt = 0;
  int          both_cnt = 0;
  int          unstable_cnt = 0;
  int          resp_cnt = 0;
  logic        prev_strobe = 1'b0;
  logic [31:0] last_addr = 32'h0;
  logic [3:0]  last_be = 4'h0;
  logic [31:0] last_wd = 32'h0;

  always @(negedge clk) begin
    if (bus.read && bus.write) both_cnt <= both_cnt + 1;
    if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
    if (bus.read || bus.write) begin
      strobe_cnt <= strobe_cnt + 1;
      if (prev_strobe && ({8'h0, bus.address} != last_addr || bus.byteenable != last_be ||
                          bus.writedata != last_wd))
        unstable_cnt <= unstable_cnt + 1;
      last_addr <= {8'h0, bus.address};
      last_be   <= bus.byteenable;
      last_wd   <= bus.writedata;
    end
    prev_strobe <= bus.read || bus.write;
  end

  // Scoreboard of expected {err, rdata}
  logic [32:0] sb [$];

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                      input logic [3:0] exp_be, input logic [31:0] exp_wd, input string tag);
    int          lat;
    int          strobes_before;
    logic [32:0] exp;
    strobes_before = strobe_cnt;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    chk({31'h0, bus.req_ready}, 32'h1, {tag, ".ready"});
    @(posedge clk);
    sb.push_back({exp_err, exp_rdata});
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'hDEAD_BEEF;
    bus.req_wdata = 32'h5555_5555;
    lat = 1;
    while (!bus.resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (bus.resp_valid) begin
      exp = sb.pop_front();
      chk(bus.resp_rdata, exp[31:0], {tag, ".rdata"});
      chk({31'h0, bus.resp_err}, {31'h0, exp[32]}, {tag, ".err"});
      chk(lat, exp_lat, {tag, ".latency"});
    end else begin
      chk({31'h0, bus.resp_valid}, 32'h1, {tag, ".resp_timeout"});
      void'(sb.pop_front());
    end
    if (exp_err) begin
      chk(strobe_cnt, strobes_before, {tag, ".no_strobe"});
    end else begin
      chk(last_addr, {8'h0, addr[23:2], 2'b00}, {tag, ".address"});
      chk({28'h0, last_be}, {28'h0, exp_be}, {tag, ".byteenable"});
      if (we) chk(last_wd, exp_wd, {tag, ".writedata"});
    end
  endtask

  initial begin
    int resp_before;
    reset_n        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    // Reset values
    #3;
    chk({31'h0, bus.read}, 32'h0, "rst.read");
    chk({31'h0, bus.write}, 32'h0, "rst.write");
    chk({8'h0, bus.address}, 32'h0, "rst.address");
    chk({28'h0, bus.byteenable}, 32'h0, "rst.byteenable");
    chk(bus.writedata, 32'h0, "rst.writedata");
    chk({31'h0, bus.resp_valid}, 32'h0, "rst.resp_valid");
    chk(bus.resp_rdata, 32'h0, "rst.resp_rdata");
    chk({31'h0, bus.resp_err}, 32'h0, "rst.resp_err");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({31'h0, bus.req_ready}, 32'h1, "rst.req_ready");

    // Word store then word load
    xact(1'b1, 2'd2, 1'b0, 32'h100, 32'h8001_7FFF, 32'h0, 1'b0, 2, 4'b1111, 32'h8001_7FFF, "sw");
    xact(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h8001_7FFF, 1'b0, 3, 4'b1111, 32'h0, "lw");
    // Sub-word loads
    xact(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 4'b1000, 32'h0, "lb");
    xact(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h0000_0080, 1'b0, 3, 4'b1000, 32'h0, "lbu");
    xact(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'hFFFF_8001, 1'b0, 3, 4'b1100, 32'h0, "lh");
    xact(1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 32'h0000_7FFF, 1'b0, 3, 4'b0011, 32'h0, "lhu");
    // Byte store then reload
    xact(1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_00AB, 32'h0, 1'b0, 2, 4'b0010, 32'hABAB_ABAB, "sb");
    xact(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h8001_ABFF, 1'b0, 3, 4'b1111, 32'h0, "lw_sb");
    // Halfword store to upper half, then reload with size 3 (word)
    xact(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_1234, 32'h0, 1'b0, 2, 4'b1100, 32'h1234_1234, "sh");
    xact(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h1234_ABFF, 1'b0, 3, 4'b1111, 32'h0, "lw_sz3");

    // Three wait cycles on a load
    stall_req = 3;
    xact(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 32'h0000_00FF, 1'b0, 6, 4'b0001, 32'h0, "lbu_wait");
    stall_req = 0;
    chk(unstable_cnt, 0, "bus_stable");

    // Misaligned requests
    xact(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1, 4'h0, 32'h0, "lw_misal");
    xact(1'b0, 2'd1, 1'b1, 32'h101, 32'h0, 32'h0, 1'b1, 1, 4'h0, 32'h0, "lh_misal");

    // Reset during a stalled read
    stall_req = 100;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h100;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk({31'h0, bus.read}, 32'h1, "abort.read_before");
    resp_before = resp_cnt;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk({31'h0, bus.read}, 32'h0, "abort.read_drop");
    chk({31'h0, bus.req_ready}, 32'h0, "abort.ready_low");
    repeat (3) @(negedge clk);
    reset_n   = 1'b1;
    stall_req = 0;
    @(posedge clk);
    @(negedge clk);
    chk({31'h0, bus.req_ready}, 32'h1, "abort.ready_after");
    repeat (2) @(negedge clk);
    chk(resp_cnt, resp_before, "abort.no_resp");
    xact(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h0000_1234, 1'b0, 3, 4'b1100, 32'h0, "lh_after");

    chk(both_cnt, 0, "read_write_exclusive");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/mips_cpu_lsu.md
# mips_cpu_lsu

Load/store unit between the MIPS CPU datapath and the Avalon-MM data memory bus. It accepts one byte, halfword or word access per request from the core and converts it to a single word-aligned bus transaction with lane byteenables and replicated write data. It stalls on `waitrequest` and returns load data to the core shifted down and sign- or zero-extended. Misaligned accesses are rejected with an error response and no bus traffic.

## Interface
- `ADDR_W`, 24: bus byte-address width; `req_addr[ADDR_W-1:0]` is used, upper bits are ignored.
- `clk` input 1: system clock, all state on rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: core request present.
- `req_ready` output 1: unit can accept a request.
- `req_we` input 1: 1 store, 0 load.
- `req_size` input 2: 0 byte, 1 halfword, 2 word; 3 is treated as word.
- `req_signed` input 1: sign-extend loads (lb/lh); ignored for stores and words.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-justified.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_err` output 1: misaligned access, qualified by `resp_valid`.
- `address` output ADDR_W: word-aligned bus address, low 2 bits 0.
- `read` output 1: bus read strobe.
- `write` output 1: bus write strobe.
- `byteenable` output 4: active byte lanes.
- `writedata` output 32: lane-positioned store data.
- `waitrequest` input 1: bus stall.
- `readdata` input 32: bus read data, lane-positioned, valid the cycle after read acceptance.

## Operation
- FSM states: IDLE, RD, WR, RLAT. `req_ready`=1 only in IDLE.
- Handshake: the request is accepted on an edge with `req_valid`&&`req_ready`. All request fields are registered at acceptance and may change afterwards.
- Alignment: halfword requires `addr[0]`=0; word requires `addr[1:0]`=0. A misaligned request stays in IDLE and pulses `resp_valid`=1 with `resp_err`=1 and `resp_rdata`=0 in the next cycle. It causes no bus strobe.
- Byteenable generation:
  - byte: `4'b0001 << addr[1:0]`.
  - halfword: `addr[1]` ? 1100 : 0011.
  - word: 1111.
- `writedata`: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- IDLE→RD (load) or IDLE→WR (store) on an aligned acceptance. `read`/`write`, `address`, `byteenable` and `writedata` are registered and stable for the whole RD/WR residency.
- RD/WR: hold while `waitrequest`=1. On an edge with `waitrequest`=0:
  - RD→RLAT.
  - WR→IDLE, with the `resp_valid` pulse in the next cycle.
- RLAT: `readdata` is captured on the next edge. Result = `readdata >> (8*addr[1:0])`, truncated to the size, then extended by `req_signed`. Then →IDLE with `resp_valid`=1.
- `read` and `write` are never 1 simultaneously. At most one transaction is outstanding.
- `resp_valid` may coincide with `req_ready`=1, so back-to-back requests are legal.

## Timing
- Reset (async, immediate) values:
  - state IDLE.
  - `read`=`write`=0, `address`=0, `byteenable`=0, `writedata`=0.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - `req_ready`=1 after the first edge with `reset_n` high.
- Reset mid-transaction abandons it. No response is produced for the abandoned access.
- Store, zero wait: accept E0, `write`=1 in cycle 1, `resp_valid` in cycle 2. Total 2 cycles.
- Load, zero wait: accept E0, `read`=1 in cycle 1, RLAT in cycle 2, `resp_valid` in cycle 3. Total 3 cycles.
- Each cycle of `waitrequest`=1 in RD/WR adds exactly one cycle.
- Misaligned: `resp_valid` in cycle 1.
- `resp_rdata`/`resp_err` hold their values until the next response; they are meaningful only while `resp_valid`=1.

## Test plan
- Store word 0x8001_7FFF to 0x100 (`byteenable` 1111, `writedata` 0x80017FFF). Then a word load from 0x100 returns 0x80017FFF, with `resp_valid` exactly 3 cycles after acceptance.
- Sub-word loads from the same word:
  - lb 0x103 → 0xFFFFFF80.
  - lbu 0x103 → 0x00000080.
  - lh 0x102 → 0xFFFF8001.
  - lhu 0x100 → 0x00007FFF.
  - Byteenables observed: 1000, 1000, 1100, 0011.
- sb 0xAB to 0x101: `byteenable` 0010, `writedata` 0xABABABAB, `address` 0x100. A following lw 0x100 returns 0x8001ABFF.
- `waitrequest` held 3 cycles on a load: `read`, `address` and `byteenable` are stable throughout, and `resp_valid` arrives at cycle 6.
- Misaligned lw 0x102 and lh 0x101: no `read` or `write` pulse, `resp_valid`+`resp_err`=1 in cycle 1, `resp_rdata`=0.
- Assert `reset_n` low during RD with `waitrequest`=1:
  - `read` drops to 0 immediately.
  - No `resp_valid`.
  - After release, `req_ready`=1 and a new load completes normally.
